// File: rtl/dot_stream_ctrl_pkg.sv
// Shared constants and helpers for the 8-lane FP dot-product stream controller.
package dot_pkg;
    localparam int LANES       = 8;
    localparam int WORD_W      = 32;
    localparam int MUL_LAT_DEF = 2;
    localparam int ADD_LAT_DEF = 2;

    // One multiplier stage followed by a balanced adder tree over all lanes.
    function automatic int pipe_lat(input int mul_lat, input int add_lat);
        return mul_lat + $clog2(LANES) * add_lat;
    endfunction

    function automatic int lane_lo(input int lane);
        return lane * WORD_W;
    endfunction
endpackage

// File: rtl/dot_stream_ctrl_if.sv
// Operand-in / result-out valid-ready stream bundle.
interface dot_stream_ctrl_if;
    import dot_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*WORD_W-1:0]   in_x;
    logic [LANES*WORD_W-1:0]   in_y;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_z;

    modport master (output in_valid, in_x, in_y, out_ready,
                    input  in_ready, out_valid, out_z);
    modport slave  (input  in_valid, in_x, in_y, out_ready,
                    output in_ready, out_valid, out_z);
endinterface

// File: rtl/dot_res_fifo.sv
// Synchronous result FIFO; read data is the head entry, zero while empty.
module dot_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_wr, do_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign rd_data = empty ? '0 : mem_q[rp_q];

    // A write into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    always_comb begin
        wp_d  = do_wr ? nxt(wp_q) : wp_q;
        rp_d  = do_rd ? nxt(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q] <= wr_data;
    end
endmodule

// File: rtl/dot_stream_ctrl.sv
// Credit-based issue/collect controller around the fixed-latency dot-product datapath.
module dot_stream_ctrl
    import dot_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int ADD_LAT    = ADD_LAT_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    dot_stream_ctrl_if.slave        strm,
    output logic [LANES*WORD_W-1:0] dp_x,
    output logic [LANES*WORD_W-1:0] dp_y,
    input  logic [WORD_W-1:0]       dp_z,
    output logic                    busy,
    output logic [15:0]             done_cnt
);
    localparam int PIPE_LAT = pipe_lat(MUL_LAT, ADD_LAT);
    localparam int OW       = $clog2(FIFO_DEPTH + 1);

    logic [OW-1:0]             occ_q, occ_d;
    logic [PIPE_LAT:0]         vld_sr_q, vld_sr_d;
    logic [LANES*WORD_W-1:0]   dp_x_q, dp_x_d, dp_y_q, dp_y_d;
    logic [15:0]               done_q, done_d;
    logic                      accept, pop, fifo_empty, fifo_full;

    // Credits cover both in-flight vectors and queued results, so ready never sees out_ready.
    assign strm.in_ready  = (occ_q < OW'(FIFO_DEPTH));
    assign strm.out_valid = !fifo_empty;
    assign accept         = strm.in_valid && strm.in_ready;
    assign pop            = strm.out_valid && strm.out_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign dp_x_d[lane_lo(g) +: WORD_W] = accept ? strm.in_x[lane_lo(g) +: WORD_W] : '0;
        assign dp_y_d[lane_lo(g) +: WORD_W] = accept ? strm.in_y[lane_lo(g) +: WORD_W] : '0;
    end

    always_comb begin
        occ_d    = occ_q + OW'(accept) - OW'(pop);
        vld_sr_d = {vld_sr_q[PIPE_LAT-1:0], accept};
        done_d   = done_q + 16'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            vld_sr_q <= '0;
            dp_x_q   <= '0;
            dp_y_q   <= '0;
            done_q   <= '0;
        end else begin
            occ_q    <= occ_d;
            vld_sr_q <= vld_sr_d;
            dp_x_q   <= dp_x_d;
            dp_y_q   <= dp_y_d;
            done_q   <= done_d;
        end
    end

    dot_res_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_sr_q[PIPE_LAT]),
        .wr_data (dp_z),
        .rd_en   (pop),
        .rd_data (strm.out_z),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign dp_x     = dp_x_q;
    assign dp_y     = dp_y_q;
    assign busy     = (occ_q != '0);
    assign done_cnt = done_q;

    a_no_drop: assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && vld_sr_q[PIPE_LAT] && !pop));
endmodule

// File: tb/tb_dot_stream_ctrl.sv
// Directed bench for dot_stream_ctrl with a behavioural fixed-latency datapath beside it.
module tb_dot_stream_ctrl;
    import dot_pkg::*;

    localparam int PL = pipe_lat(MUL_LAT_DEF, ADD_LAT_DEF);
    localparam logic [31:0] ONE = 32'h3F80_0000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [LANES*WORD_W-1:0] dp_x, dp_y;
    logic [WORD_W-1:0]       dp_z;
    logic                    busy;
    logic [15:0]             done_cnt;
    logic [31:0]             zp [PL];

    int tests = 0, fails = 0;
    int seq = 0;
    int done_exp = 0;
    logic [31:0] q [$];

    dot_stream_ctrl_if bus ();

    dot_stream_ctrl dut (
        .clk(clk), .rst(rst), .strm(bus), .dp_x(dp_x), .dp_y(dp_y),
        .dp_z(dp_z), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e11;
        if (r == 0.0) return 32'd0;
        d   = $realtobits(r);
        e11 = d[62:52] - 11'd896;
        return {d[63], e11[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] dot_ref(input logic [255:0] x, input logic [255:0] y);
        real acc = 0.0;
        for (int j = 0; j < LANES; j++) acc = acc + f2r(x[32*j +: 32]) * f2r(y[32*j +: 32]);
        return r2f(acc);
    endfunction

    // Datapath stand-in: result of the operands on dp_x/dp_y appears PL cycles later.
    initial for (int k = 0; k < PL; k++) zp[k] = '0;
    always @(posedge clk) begin
        zp[0] <= dot_ref(dp_x, dp_y);
        for (int k = 1; k < PL; k++) zp[k] <= zp[k-1];
    end
    assign dp_z = zp[PL-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: expected result pushed per accept, compared on every pop.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("occ_le_depth", 64'(q.size() <= 16), 64'd1);
            chk("ready_vs_occ", 64'(bus.in_ready), 64'(q.size() < 16));
            chk("no_stale_valid", 64'(bus.out_valid && q.size() == 0), 64'd0);
            if (bus.out_valid && bus.out_ready && q.size() != 0)
                chk("sb_out_z", 64'(bus.out_z), 64'(q.pop_front()));
            if (bus.in_valid && bus.in_ready)
                q.push_back(dot_ref(bus.in_x, bus.in_y));
        end
    end

    task automatic set_all(input logic [31:0] xa, input logic [31:0] ya);
        for (int j = 0; j < LANES; j++) begin
            bus.in_x[32*j +: 32] = xa;
            bus.in_y[32*j +: 32] = ya;
        end
    endtask

    task automatic set_vec(input int n);
        for (int j = 0; j < LANES; j++) begin
            bus.in_x[32*j +: 32] = r2f(real'(n + j));
            bus.in_y[32*j +: 32] = ONE;
        end
    endtask

    task automatic run_single(input logic [31:0] xa, input logic [31:0] ya, input logic [31:0] z);
        logic [255:0] xv;
        set_all(xa, ya);
        xv = bus.in_x;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("single_dp_x_c%0d", c), 64'(dp_x == ((c == 1) ? xv : 256'd0)), 64'd1);
            chk($sformatf("single_valid_c%0d", c), 64'(bus.out_valid), 64'(c == 10));
            if (c == 10) chk("single_out_z", 64'(bus.out_z), 64'(z));
        end
        done_exp++;
        chk("single_done_cnt", 64'(done_cnt), 64'(16'(done_exp)));
        chk("single_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drive_n(input string nm, input int n, input bit tog, input int bound);
        int cnt = 0, c = 0;
        bit a;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_vec(seq);
        while (cnt < n && c < bound) begin
            @(negedge clk);
            a = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (a) begin cnt++; seq++; set_vec(seq); end
            c++;
            bus.out_ready = tog ? ~bus.out_ready : 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk({nm, "_accepts"}, 64'(cnt), 64'(n));
        repeat (30) @(posedge clk);
        #1;
        chk({nm, "_drained"}, 64'(q.size()), 64'd0);
        done_exp += cnt;
        chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(16'(done_exp)));
    endtask

    typedef struct { logic [31:0] xa, ya, z; } vec_t;
    vec_t tbl [6];

    initial begin
        int acc;
        bit a, have_z;
        logic [31:0] z0;

        tbl[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4180_0000};  // 8*1*2   = 16
        tbl[1] = '{32'h3F00_0000, 32'h3F00_0000, 32'h4000_0000};  // 8*.25   = 2
        tbl[2] = '{32'h4040_0000, 32'hBF80_0000, 32'hC1C0_0000};  // 8*3*-1  = -24
        tbl[3] = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000};  // 0
        tbl[4] = '{32'h3FC0_0000, 32'h4000_0000, 32'h41C0_0000};  // 8*1.5*2 = 24
        tbl[5] = '{32'h3E80_0000, 32'h3E00_0000, 32'h3E80_0000};  // 8/32    = .25

        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_x = '0; bus.in_y = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_z", 64'(bus.out_z), 64'd0);
        chk("rst_dp_x", 64'(dp_x == '0 && dp_y == '0), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single vectors with hand-computed results.
        for (int i = 0; i < 6; i++) run_single(tbl[i].xa, tbl[i].ya, tbl[i].z);

        // 32 back-to-back vectors, full-rate drain.
        for (int c = 0; c < 46; c++) begin
            bus.in_valid = (c < 32);
            if (c < 32) set_vec(seq + c);
            @(negedge clk);
            if (c < 32) chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
            chk($sformatf("b2b_valid_c%0d", c), 64'(bus.out_valid), 64'(c >= 10 && c < 42));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        seq += 32;
        done_exp += 32;
        chk("b2b_done_cnt", 64'(done_cnt), 64'(16'(done_exp)));

        // Full backpressure: credits run out at 16, head stays stable.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; set_vec(seq);
        acc = 0; have_z = 1'b0; z0 = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            a = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (have_z) chk("bp_out_z_hold", 64'(bus.out_z), 64'(z0));
                else begin z0 = bus.out_z; have_z = 1'b1; end
            end
            @(posedge clk); #1;
            if (a) begin acc++; seq++; set_vec(seq); end
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", 64'(acc), 64'd16);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_at_pop", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
        repeat (25) @(posedge clk);
        #1;
        done_exp += 16;
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_done_cnt", 64'(done_cnt), 64'(16'(done_exp)));

        // Alternating out_ready with continuous offer.
        drive_n("toggle", 40, 1'b1, 400);

        // Reset with three vectors in flight.
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin set_vec(seq + c); @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        seq += 3;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", 64'(bus.out_valid), 64'd0);
        end
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        done_exp = 0;
        run_single(tbl[0].xa, tbl[0].ya, tbl[0].z);

        // 65536 more deliveries wrap the counter back to 1.
        drive_n("wrap", 65536, 1'b0, 65600);
        chk("wrap_done_is_1", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dot_stream_ctrl.md
Name: dot_stream_ctrl

Overview:
Flow-control wrapper and sequencer for the 8-lane FP dot-product datapath (8 multipliers feeding a 3-level adder tree, no stall input).
- Accepts operand vectors over a valid/ready handshake and registers them into the datapath.
- Tracks each issued vector through the fixed pipeline latency with a valid shift register.
- Captures results into an output FIFO and presents them downstream with valid/ready.
- Credit-based issue guarantees no result is ever dropped under downstream backpressure.

Parameters:
- MUL_LAT, 2, FP multiplier latency in cycles.
- ADD_LAT, 2, FP adder latency in cycles.
- PIPE_LAT, MUL_LAT+3*ADD_LAT, total datapath latency (derived, not overridden).
- FIFO_DEPTH, 16, result FIFO entries; must be at least 1; full throughput needs at least PIPE_LAT+3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand vector valid
- in_ready  out  1  controller can accept a vector
- in_x  in  256  x0..x7, lane i at bits [32i+31:32i]
- in_y  in  256  y0..y7, same packing
- dp_x  out  256  registered operands to the datapath x inputs
- dp_y  out  256  registered operands to the datapath y inputs
- dp_z  in  32  datapath result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_z  out  32  result at FIFO head
- busy  out  1  occupancy non-zero
- done_cnt  out  16  count of delivered results, wraps at 65535→0

Behaviour:
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (occ < FIFO_DEPTH). It is a function of registered state only, with no combinational path from out_ready.
- Occupancy counter occ (width clog2(FIFO_DEPTH+1)) counts in-flight vectors plus FIFO entries:
  - +1 on accept, −1 on pop.
  - Accept and pop in the same cycle leave occ unchanged.
  - occ never exceeds FIFO_DEPTH, so a FIFO write can never find the FIFO full.
- Timing for a vector accepted in cycle 0:
  - dp_x/dp_y hold its data in cycle 1.
  - In cycles with no accept, dp_x/dp_y are driven to 0.
  - vld_sr[0] is set in cycle 1 and shifts one stage per cycle. vld_sr has length PIPE_LAT+1.
  - When vld_sr[PIPE_LAT] is 1 (cycle 1+PIPE_LAT), dp_z is written to the FIFO at that edge.
  - out_valid rises in cycle 2+PIPE_LAT at the earliest.
  - Minimum accept-to-out_valid latency is PIPE_LAT+2 cycles (10 at defaults).
- FIFO: first-in first-out order. out_z is the head entry while out_valid=1. out_z must not change while out_valid=1 and out_ready=0.
- Throughput: one accept per cycle sustained while out_ready=1 and FIFO_DEPTH ≥ PIPE_LAT+3.
- done_cnt increments on every pop and wraps modulo 2^16.
- busy = (occ != 0).
- Reset values: in_ready=1, out_valid=0, out_z=0, dp_x=0, dp_y=0, busy=0, done_cnt=0, occ=0, vld_sr all 0, FIFO empty.
- Reset mid-operation:
  - All in-flight tags are cleared.
  - Datapath results emerging after reset are discarded, because their vld_sr bits are 0.
  - No stale result appears on out_valid.
- Corner cases:
  - in_valid high while occ=FIFO_DEPTH: no accept. The upstream holds its data, since the valid/ready protocol requires stable data while valid=1 and ready=0.
  - A FIFO write and a pop in the same cycle are both performed, including when the FIFO is empty and a pop would be illegal. The empty case cannot occur because out_valid=0 then.

Decomposition:
- Shared package dot_pkg holds:
  - LANES=8, WORD_W=32.
  - Default MUL_LAT and ADD_LAT.
  - A function computing PIPE_LAT from MUL_LAT and ADD_LAT.
  - A function for the packed lane slice offsets.
- One sub-module dot_res_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports wr_en/wr_data/rd_en/rd_data/empty/full, and synchronous active-high reset.
- The datapath is instantiated beside this controller at the next level up, not inside it.

Test Plan:
1. Single vector, in_x lanes all 1.0 (0x3F800000), in_y lanes all 2.0, out_ready=1. Expect:
   - dp_x nonzero only in cycle 1.
   - out_valid in cycle 10 only, out_z=0x41800000 (16.0).
   - done_cnt=1, busy=0 afterwards.
2. 32 back-to-back vectors with out_ready=1. Expect:
   - in_ready stays 1 throughout.
   - 32 consecutive out_valid cycles starting at cycle 10.
   - Results in issue order; done_cnt=32.
3. out_ready=0, in_valid held 1. Expect:
   - Exactly 16 accepts, then in_ready=0 with occ=16.
   - out_z stable.
   - Then out_ready=1: 16 results in order, and in_ready returns to 1 in the cycle after the first pop.
4. out_ready toggled 1/0 every cycle with continuous in_valid. Expect no loss or duplication (scoreboard match) and occ ≤ 16 at all times.
5. rst pulsed 4 cycles after accepting 3 vectors. Expect:
   - out_valid never asserts for those vectors.
   - in_ready=1 and done_cnt=0 after reset.
   - A fresh vector then returns correctly at latency 10.
6. done_cnt preset scenario: deliver 65537 results. Expect done_cnt=1 (wrap).
